// File: rtl/clk_gate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_gate_pkg
// Brief   : Shared types and defaults for the per-unit clock-gating controller
// Revision: 1.0 - initial release
// ============================================================================
package clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_IDLE  = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    localparam int unsigned c_idle_cycles_dflt = 16;
    localparam int unsigned c_wake_cycles_dflt = 2;

    // One counter serves both the idle and the wake countdown.
    function automatic int unsigned cg_cnt_width(input int unsigned idle_cycles,
                                                 input int unsigned wake_cycles);
        int unsigned max_val;
        max_val = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(max_val + 1);
    endfunction

endpackage : clk_gate_pkg
`default_nettype wire

// File: rtl/clk_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : clk_gate_ctrl_if
// Brief   : Unit request/busy/grant and clock-enable bundle of clk_gate_ctrl
// Revision: 1.0 - initial release
// ============================================================================
interface clk_gate_ctrl_if #(
    parameter int unsigned N_UNITS = 4
);
    logic               cfg_gate_en_i;
    logic               scan_en_i;
    logic [N_UNITS-1:0] unit_req_i;
    logic [N_UNITS-1:0] unit_busy_i;
    logic [N_UNITS-1:0] unit_gnt_o;
    logic [N_UNITS-1:0] unit_clk_en_o;
    logic [N_UNITS-1:0] unit_gated_o;
    logic               wake_busy_o;

    modport master (
        output cfg_gate_en_i,
        output scan_en_i,
        output unit_req_i,
        output unit_busy_i,
        input  unit_gnt_o,
        input  unit_clk_en_o,
        input  unit_gated_o,
        input  wake_busy_o
    );

    modport slave (
        input  cfg_gate_en_i,
        input  scan_en_i,
        input  unit_req_i,
        input  unit_busy_i,
        output unit_gnt_o,
        output unit_clk_en_o,
        output unit_gated_o,
        output wake_busy_o
    );

endinterface : clk_gate_ctrl_if
`default_nettype wire

// File: rtl/cg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cg_rr_arbiter
// Brief   : N-way round-robin arbiter, one-hot grant, pointer moves past winner
// Revision: 1.0 - initial release
// ============================================================================
module cg_rr_arbiter #(
    parameter int N = 4
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    input  wire logic [N-1:0] req,
    input  wire logic         en,
    output logic      [N-1:0] gnt
);

    localparam int c_ptr_w = (N > 1) ? $clog2(N) : 1;

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_idx;
    logic [c_ptr_w-1:0] w_next_ptr;
    logic [N-1:0]       w_pick;
    logic               w_any;

    // Scan from the pointer upwards, wrapping, and take the first requester.
    always_comb begin
        w_idx      = '0;
        w_next_ptr = r_ptr;
        w_pick     = '0;
        w_any      = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = c_ptr_w'((int'(r_ptr) + k) % N);
            if (!w_any && req[w_idx]) begin
                w_pick[w_idx] = 1'b1;
                w_next_ptr    = c_ptr_w'((int'(w_idx) + 1) % N);
                w_any         = 1'b1;
            end
        end
    end

    assign gnt = en ? w_pick : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (en && w_any) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule : cg_rr_arbiter
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_gate_ctrl
// Brief   : Per-unit idle clock gating with one-at-a-time round-robin wake-up
// Revision: 1.0 - initial release
// ============================================================================
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned N_UNITS     = 4,
    parameter int unsigned IDLE_CYCLES = c_idle_cycles_dflt,
    parameter int unsigned WAKE_CYCLES = c_wake_cycles_dflt
) (
    input  wire logic      clk_i,
    input  wire logic      rst_ni,
    clk_gate_ctrl_if.slave bus
);

    localparam int unsigned c_cnt_w = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);

    localparam logic [c_cnt_w-1:0] c_idle_load = c_cnt_w'(IDLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_wake_load = c_cnt_w'(WAKE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    logic [N_UNITS-1:0] w_idle;
    logic [N_UNITS-1:0] w_active;
    logic [N_UNITS-1:0] w_gated;
    logic [N_UNITS-1:0] w_waking;
    logic [N_UNITS-1:0] w_wake_cand;
    logic [N_UNITS-1:0] w_wake_gnt;
    logic               w_slot_free;

    assign w_idle = ~bus.unit_req_i & ~bus.unit_busy_i & {N_UNITS{bus.cfg_gate_en_i}};

    // Disabling gating turns every gated unit into a wake candidate.
    assign w_wake_cand = w_gated & (bus.unit_req_i | {N_UNITS{~bus.cfg_gate_en_i}});

    // Only one unit may ramp its clock at a time to bound di/dt.
    assign w_slot_free = ~|w_waking;

    cg_rr_arbiter #(
        .N (int'(N_UNITS))
    ) u_wake_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (w_wake_cand),
        .en     (w_slot_free),
        .gnt    (w_wake_gnt)
    );

    for (genvar gi = 0; gi < int'(N_UNITS); gi++) begin : g_unit
        cg_state_e          r_state;
        logic [c_cnt_w-1:0] r_cnt;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= CG_RUN;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    CG_RUN: begin
                        if (w_idle[gi]) begin
                            r_state <= CG_IDLE;
                            r_cnt   <= c_idle_load;
                        end
                    end
                    CG_IDLE: begin
                        if (!w_idle[gi]) begin
                            r_state <= CG_RUN;
                        end else if (r_cnt == c_cnt_one) begin
                            r_state <= CG_GATED;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    CG_GATED: begin
                        if (w_wake_gnt[gi]) begin
                            r_state <= CG_WAKE;
                            r_cnt   <= c_wake_load;
                        end
                    end
                    CG_WAKE: begin
                        if (r_cnt == c_cnt_one) begin
                            r_state <= CG_RUN;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    default: begin
                        r_state <= CG_RUN;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        // The clock still runs in IDLE, so a request there is granted at once.
        assign w_active[gi] = (r_state == CG_RUN) || (r_state == CG_IDLE);
        assign w_gated[gi]  = (r_state == CG_GATED);
        assign w_waking[gi] = (r_state == CG_WAKE);
    end

    assign bus.unit_gnt_o    = bus.unit_req_i & w_active & {N_UNITS{rst_ni}};
    assign bus.unit_clk_en_o = ~w_gated | {N_UNITS{bus.scan_en_i}};
    assign bus.unit_gated_o  = w_gated;
    assign bus.wake_busy_o   = ~w_slot_free;

endmodule : clk_gate_ctrl
`default_nettype wire
